// File: rtl/adc_ctrl_pkg.sv
// Shared frame geometry, FSM state encoding and frame helpers for the ADC
// capture controller.
package adc_ctrl_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_BITS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    // True when any of the leading (expected-zero) bits of a frame is set.
    function automatic logic lead_nonzero(input logic [FRAME_BITS-1:0] frame);
        return |frame[FRAME_BITS-1 -: LEAD_BITS];
    endfunction

endpackage

// File: rtl/adc_ctrl_shift.sv
// Serial-in, MSB-first frame shift register; one instance per ADC data line.
module adc_shift
    import adc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  sd,
    output logic [FRAME_BITS-1:0] data
);

    // Shift one serial bit in at the LSB when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {data[FRAME_BITS-2:0], sd};
        end else begin
            data <= data;
        end
    end

endmodule

// File: rtl/adc_ctrl.sv
// Dual-line SPI-style ADC read controller: one 16-bit frame per start request,
// left/right samples presented in parallel with a one-cycle valid strobe.
module adc_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int SCK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic [DATA_BITS-1:0] sample_l,
    output logic [DATA_BITS-1:0] sample_r,
    output logic                 valid,
    output logic                 lead_err,
    output logic                 cs_n,
    output logic                 sck,
    input  logic                 sd0,
    input  logic                 sd1
);

    localparam logic [7:0] DIV_LAST   = 8'(SCK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam logic [3:0] BIT_LAST   = 4'(FRAME_BITS - 1);

    state_t                state_r;
    logic [7:0]            div_cnt_r;
    logic [7:0]            quiet_cnt_r;
    logic [3:0]            bit_cnt_r;
    logic [FRAME_BITS-1:0] shift_l_s;
    logic [FRAME_BITS-1:0] shift_r_s;
    logic                  half_done_s;
    logic                  shift_en_s;

    assign half_done_s = (div_cnt_r == DIV_LAST);
    // Data is captured on the last clk of the sck-low half, just before sck rises.
    assign shift_en_s  = (state_r == ST_CONV) && !sck && half_done_s;

    adc_shift u_shift_l (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .sd       (sd0),
        .data     (shift_l_s)
    );

    adc_shift u_shift_r (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .sd       (sd1),
        .data     (shift_r_s)
    );

    // Frame FSM with sck divider, bit counter, quiet timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= 8'd0;
            quiet_cnt_r <= 8'd0;
            bit_cnt_r   <= 4'd0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            lead_err    <= 1'b0;
            sample_l    <= '0;
            sample_r    <= '0;
            cs_n        <= 1'b1;
            sck         <= 1'b1;
        end else begin
            valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cs_n <= 1'b1;
                    sck  <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        state_r   <= ST_CONV;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        sck       <= 1'b0;
                        div_cnt_r <= 8'd0;
                        bit_cnt_r <= 4'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    if (!half_done_s) begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end else begin
                        div_cnt_r <= 8'd0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else if (bit_cnt_r == BIT_LAST) begin
                            // Frame complete: release the ADC and publish both samples.
                            state_r     <= ST_QUIET;
                            cs_n        <= 1'b1;
                            sck         <= 1'b1;
                            sample_l    <= shift_l_s[DATA_BITS-1:0];
                            sample_r    <= shift_r_s[DATA_BITS-1:0];
                            lead_err    <= lead_nonzero(shift_l_s) | lead_nonzero(shift_r_s);
                            valid       <= 1'b1;
                            quiet_cnt_r <= 8'd0;
                        end else begin
                            sck       <= 1'b0;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_QUIET: begin
                    if (quiet_cnt_r == QUIET_LAST) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        quiet_cnt_r <= quiet_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    cs_n    <= 1'b1;
                    sck     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_ctrl.sv
// Directed bench for adc_ctrl: default-timing instance A and fast instance B
// (SCK_DIV=1, QUIET_CYCLES=1), each fed by a behavioural dual-line ADC model.
module tb_adc_ctrl;

    logic        clk;
    logic        reset;
    logic        start_a, start_b;
    logic        busy_a, busy_b;
    logic [11:0] sample_l_a, sample_r_a, sample_l_b, sample_r_b;
    logic        valid_a, valid_b, lead_err_a, lead_err_b;
    logic        cs_n_a, cs_n_b, sck_a, sck_b;
    logic        sd0_a, sd1_a, sd0_b, sd1_b;

    logic [15:0] fl_a, fr_a, fl_b, fr_b;
    int          idx_a, idx_b, falls_a, falls_b;
    int          cyc;
    int          checks, failures;

    typedef struct {
        logic [15:0] fl;
        logic [15:0] fr;
        logic [11:0] el;
        logic [11:0] er;
        logic        ee;
    } vec_t;
    vec_t vecs[6];

    adc_ctrl #(.SCK_DIV(2), .QUIET_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
        .sample_l(sample_l_a), .sample_r(sample_r_a), .valid(valid_a),
        .lead_err(lead_err_a), .cs_n(cs_n_a), .sck(sck_a), .sd0(sd0_a), .sd1(sd1_a)
    );

    adc_ctrl #(.SCK_DIV(1), .QUIET_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
        .sample_l(sample_l_b), .sample_r(sample_r_b), .valid(valid_b),
        .lead_err(lead_err_b), .cs_n(cs_n_b), .sck(sck_b), .sd0(sd0_b), .sd1(sd1_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model A: next bit after each sck fall while selected; fall count kept per frame.
    initial begin
        idx_a = 0; falls_a = 0; sd0_a = 1'b0; sd1_a = 1'b0;
        forever begin
            @(negedge sck_a or posedge cs_n_a);
            #1;
            if (cs_n_a) begin
                if (idx_a != 0) falls_a = idx_a;
                idx_a = 0;
            end else begin
                if (idx_a < 16) begin
                    sd0_a = fl_a[15-idx_a];
                    sd1_a = fr_a[15-idx_a];
                end
                idx_a++;
            end
        end
    end

    // ADC model B.
    initial begin
        idx_b = 0; falls_b = 0; sd0_b = 1'b0; sd1_b = 1'b0;
        forever begin
            @(negedge sck_b or posedge cs_n_b);
            #1;
            if (cs_n_b) begin
                if (idx_b != 0) falls_b = idx_b;
                idx_b = 0;
            end else begin
                if (idx_b < 16) begin
                    sd0_b = fl_b[15-idx_b];
                    sd1_b = fr_b[15-idx_b];
                end
                idx_b++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One full frame on instance A (sel=0) or B (sel=1), then check the result.
    task automatic do_frame(input bit sel, input logic [15:0] fl, input logic [15:0] fr,
                            input logic [11:0] el, input logic [11:0] er, input logic ee,
                            input int exp_lat, input string nm);
        int lat;
        int guard;
        logic v;
        if (sel) begin fl_b = fl; fr_b = fr; end
        else     begin fl_a = fl; fr_a = fr; end
        guard = 0;
        while ((sel ? busy_b : busy_a) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        lat = 0;
        v = 1'b0;
        while (!v && lat < 300) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            lat++;
            v = sel ? valid_b : valid_a;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_sample_l"}, sel ? sample_l_b : sample_l_a, el);
        chk({nm, "_sample_r"}, sel ? sample_r_b : sample_r_a, er);
        chk({nm, "_lead_err"}, sel ? lead_err_b : lead_err_a, ee);
        chk({nm, "_cs_n_end"}, sel ? cs_n_b : cs_n_a, 1'b1);
        chk({nm, "_sck_falls"}, sel ? falls_b : falls_a, 16);
        @(negedge clk);
        chk({nm, "_valid_one_cycle"}, sel ? valid_b : valid_a, 1'b0);
        chk({nm, "_samples_held"}, sel ? sample_l_b : sample_l_a, el);
    endtask

    initial begin
        int bad;
        int vcyc[$];
        int run, rmin, rmax, nruns;
        bit seen_low;

        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        fl_a = 16'h0; fr_a = 16'h0; fl_b = 16'h0; fr_b = 16'h0;

        vecs[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0};
        vecs[1] = '{16'h0ABC, 16'h4123, 12'hABC, 12'h123, 1'b1};
        vecs[2] = '{16'h8FFF, 16'h0000, 12'hFFF, 12'h000, 1'b1};
        vecs[3] = '{16'h0555, 16'h0AAA, 12'h555, 12'hAAA, 1'b0};
        vecs[4] = '{16'h0000, 16'h0FFF, 12'h000, 12'hFFF, 1'b0};
        vecs[5] = '{16'h1001, 16'h0800, 12'h001, 12'h800, 1'b1};

        #145 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",     busy_a, 1'b0);
        chk("rst_valid",    valid_a, 1'b0);
        chk("rst_lead_err", lead_err_a, 1'b0);
        chk("rst_sample_l", sample_l_a, 12'h000);
        chk("rst_sample_r", sample_r_a, 12'h000);
        chk("rst_cs_n",     cs_n_a, 1'b1);
        chk("rst_sck",      sck_a, 1'b1);
        chk("rst_b_pins",   {cs_n_b, sck_b, busy_b, valid_b}, 4'b1100);

        // Long idle: pins parked, nothing busy.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!(cs_n_a && sck_a && !busy_a && !valid_a)) bad++;
        end
        chk("idle_1000", bad, 0);

        for (int i = 0; i < 6; i++)
            do_frame(1'b0, vecs[i].fl, vecs[i].fr, vecs[i].el, vecs[i].er, vecs[i].ee,
                     65, $sformatf("vec%0d", i));

        // start held high: back-to-back frames at the minimum period.
        fl_a = 16'h0321; fr_a = 16'h0654;
        @(negedge clk);
        start_a = 1'b1;
        run = 0; rmin = 9999; rmax = 0; nruns = 0; seen_low = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (valid_a) vcyc.push_back(cyc);
            if (cs_n_a) begin
                run++;
            end else begin
                if (seen_low && run > 0) begin
                    if (run < rmin) rmin = run;
                    if (run > rmax) rmax = run;
                    nruns++;
                end
                seen_low = 1'b1;
                run = 0;
            end
        end
        start_a = 1'b0;
        chk("b2b_frames", vcyc.size() >= 3, 1'b1);
        if (vcyc.size() >= 3) begin
            chk("b2b_period0", vcyc[1] - vcyc[0], 69);
            chk("b2b_period1", vcyc[2] - vcyc[1], 69);
        end
        chk("b2b_gaps", nruns >= 2, 1'b1);
        chk("b2b_cs_gap_min", rmin, 5);
        chk("b2b_cs_gap_max", rmax, 5);
        chk("b2b_sample_l", sample_l_a, 12'h321);
        chk("b2b_sample_r", sample_r_a, 12'h654);

        // Reset in the middle of a conversion frame.
        bad = 0;
        while (busy_a && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        fl_a = 16'h0ABC; fr_a = 16'h0123;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (29) @(negedge clk);
        chk("mid_cs_low", cs_n_a, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_cs_n",  cs_n_a, 1'b1);
        chk("abort_sck",   sck_a, 1'b1);
        chk("abort_busy",  busy_a, 1'b0);
        chk("abort_valid", valid_a, 1'b0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_a || sample_l_a != 12'h000 || sample_r_a != 12'h000 || !cs_n_a) bad++;
        end
        chk("abort_no_valid", bad, 0);
        do_frame(1'b0, 16'h0123, 16'h0456, 12'h123, 12'h456, 1'b0, 65, "post_abort");

        // Fastest timing instance.
        do_frame(1'b1, 16'h0FFF, 16'h0000, 12'hFFF, 12'h000, 1'b0, 33, "fast0");
        do_frame(1'b1, 16'h2A5A, 16'h05A5, 12'hA5A, 12'h5A5, 1'b1, 33, "fast1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
